gpio_spi_wb_bridge: RTL and testbench
=====================================

Name: gpio_spi_wb_bridge

Overview:
- Serial slave on four GPIO pins; acts as Wishbone master into the user project's Wishbone slave port (timer/scheduler register file).
- Lets an off-chip host read and write project registers through the openframe pads, without the Microwatt core.
- Sits in openframe_project_wrapper between gpio_in/gpio_out/gpio_oeb and the project's wb_* slave inputs.
- Fully synchronous to wb_clk_i; the SPI pins are oversampled.

Parameters:
- TIMEOUT, 64: wb_clk_i cycles allowed from stb assertion to ack_i before the cycle is aborted.
- SYNC_STAGES, 2: synchronizer depth on sclk, cs_n and mosi (minimum 2).

Ports:
- wb_clk_i  input  1  system clock; every flop is on its rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- spi_sclk  input  1  host serial clock, SPI mode 0. Maximum frequency is wb_clk_i/8.
- spi_cs_n  input  1  host chip select, active low.
- spi_mosi  input  1  host-to-bridge data, MSB first.
- spi_miso  output  1  bridge-to-host data.
- spi_miso_oeb  output  1  pad output-enable, active low. Driven 0 only while spi_cs_n is low.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  byte select. Always 4'hF during a cycle, 0 otherwise.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_dat_i  input  32  Wishbone read data.
- wbm_ack_i  input  1  Wishbone acknowledge.
- busy  output  1  high from frame start until the bridge returns to IDLE.
- err  output  1  sticky timeout flag. Cleared only by wb_rst_i.

Behaviour:
- Reset values: all wbm_* outputs 0, spi_miso 0, spi_miso_oeb 1, busy 0, err 0, FSM in IDLE, shift counters 0.
- Pin sampling: sclk, cs_n and mosi pass through SYNC_STAGES flops.
  - Rising-edge detect on synced sclk shifts in synced mosi.
  - Falling-edge detect updates spi_miso.
- cs_n high in any state except WB_WR/WB_RD forces IDLE and discards the partial frame. No WB cycle is started.
- Frame format, MSB first:
  - 8-bit command, then 32-bit address.
  - Write command 8'h02: followed by 32-bit data.
  - Read command 8'h03: followed by 8 turnaround clocks, then 32 bits the bridge drives out.
- FSM states: IDLE, CMD, ADDR, WDATA, WB_WR, WB_RD, TURN, RDATA, DRAIN.
  - IDLE -> CMD on synced cs_n falling.
  - CMD -> ADDR after 8 bits if command is 02 or 03; otherwise -> DRAIN.
  - ADDR -> WDATA (cmd 02) or WB_RD (cmd 03) after 32 bits.
  - WDATA -> WB_WR after 32 bits.
  - WB_WR -> DRAIN on ack or timeout.
  - WB_RD -> TURN on ack or timeout.
  - TURN -> RDATA after the 8th turnaround rising edge.
  - RDATA -> DRAIN after 32 bits.
  - DRAIN -> IDLE when cs_n is high. DRAIN ignores sclk and keeps miso at 0.
- WB master:
  - In the cycle the FSM enters WB_WR/WB_RD: cyc=stb=1, we=1 for WB_WR and 0 for WB_RD, sel=F, adr and dat_o = shifted values.
  - These values are held until the first cycle with ack_i=1; cyc/stb/we/sel drop on the following edge.
  - Read data is captured in that ack cycle.
  - Single transfer only; no bursts, no pipelining.
- Timeout: if ack is not seen within TIMEOUT cycles of stb rising, cyc/stb drop and err sets. A timed-out read returns 32'hFFFF_FFFF.
- cs_n deasserting during WB_WR/WB_RD: the WB cycle still completes (ack or timeout), then the FSM goes to IDLE directly. stb never drops without ack or timeout.
- Read turnaround: WB_RD lasts at most TIMEOUT+1 cycles, which must fit inside 8 sclk periods. The host therefore runs sclk ≤ wb_clk_i/8 with TIMEOUT ≤ 63.
  - If WB_RD is still active when turnaround rising edges arrive, those edges are counted.
  - If the 8th edge arrives before WB_RD exits, the bridge enters RDATA directly on exit.
- MISO: in RDATA, bit 31 is driven from TURN exit; each subsequent synced sclk falling edge presents the next bit. spi_miso is 0 in all other states.
- busy = (state != IDLE).

Test Plan:
- Write: cs low, shift 02, 3000_0004, A5A5_1234; slave acks 3 cycles after stb -> exactly one cycle with we=1, adr=3000_0004, dat_o=A5A5_1234, sel=F; cyc drops the cycle after ack; err=0.
- Read: shift 03, 3000_0008, 8 turnaround clocks; slave returns 0000_00C3 with ack after 2 cycles -> we=0 cycle, host samples 0000_00C3 on the next 32 clocks, miso_oeb=0 only while cs_n low.
- Illegal command 8'h7E followed by 64 clocks -> no wbm_cyc_o, miso stays 0; after cs_n high, busy returns 0.
- Abort: cs_n high after 20 bits of a write frame -> no WB cycle, IDLE within SYNC_STAGES+2 cycles; a following valid write executes normally.
- Timeout: read with ack never asserted -> stb high exactly TIMEOUT cycles, err=1, host reads FFFF_FFFF; err persists across frames until reset.
- Reset mid-cycle: wb_rst_i during WB_WR with stb high -> all wbm_* outputs 0 and miso_oeb=1 on the next edge, FSM IDLE.

Source files
------------

// File: rtl/gpio_spi_wb_bridge_if.sv
// Wishbone master-side bus used by the GPIO SPI bridge.
// The master modport is the bridge; the slave modport is the project register file.
interface gpio_spi_wb_bridge_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/gpio_spi_wb_bridge.sv
// SPI mode-0 slave on GPIO pins that issues single Wishbone read/write cycles.
// Frame: cmd(8) addr(32) then wdata(32) or 8 turnaround clocks + rdata(32).
module gpio_spi_wb_bridge #(
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        spi_sclk,
  input  logic                        spi_cs_n,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  output logic                        spi_miso_oeb,
  gpio_spi_wb_bridge_if.master        wbm,
  output logic                        busy,
  output logic                        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, WDATA, WB_WR, WB_RD, TURN, RDATA, DRAIN
  } state_t;

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic                   sclk_prev_reg, cs_prev_reg;
  logic [5:0]             bit_cnt_reg;
  logic [3:0]             turn_cnt_reg;
  logic [31:0]            shift_reg, rdata_reg;
  logic                   is_read_reg;
  logic [TW-1:0]          timer_reg;
  logic                   miso_reg, err_reg;
  logic                   cyc_reg, stb_reg, we_reg;
  logic [3:0]             sel_reg;
  logic [31:0]            adr_reg, dat_reg;

  logic        sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall, timeout;
  logic [31:0] shift_in, rd_value;
  logic [3:0]  turn_inc;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  assign cs_fall   = ~cs_s & cs_prev_reg;
  assign shift_in  = {shift_reg[30:0], mosi_s};
  assign timeout   = (timer_reg == TLAST);
  assign rd_value  = wbm.wbm_ack_i ? wbm.wbm_dat_i : 32'hFFFF_FFFF;
  // Turnaround edges seen so far, including one arriving this cycle.
  assign turn_inc  = turn_cnt_reg + {3'd0, sclk_rise};

  assign wbm.wbm_cyc_o = cyc_reg;
  assign wbm.wbm_stb_o = stb_reg;
  assign wbm.wbm_we_o  = we_reg;
  assign wbm.wbm_sel_o = sel_reg;
  assign wbm.wbm_adr_o = adr_reg;
  assign wbm.wbm_dat_o = dat_reg;
  assign spi_miso      = miso_reg;
  // The pad is only driven while the host selects us and a frame is underway.
  assign spi_miso_oeb  = spi_cs_n | (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign err           = err_reg;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
      bit_cnt_reg   <= '0;
      turn_cnt_reg  <= '0;
      shift_reg     <= '0;
      rdata_reg     <= '0;
      is_read_reg   <= 1'b0;
      timer_reg     <= '0;
      miso_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      adr_reg       <= '0;
      dat_reg       <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;

      case (state_reg)
        IDLE: begin
          miso_reg <= 1'b0;
          if (cs_fall) begin
            state_reg   <= CMD;
            bit_cnt_reg <= '0;
          end
        end
        CMD: begin
          if (cs_s) begin
            state_reg <= IDLE;
          end else if (sclk_rise) begin
            shift_reg   <= shift_in;
            bit_cnt_reg <= bit_cnt_reg + 6'd1;
            if (bit_cnt_reg == 6'd7) begin
              bit_cnt_reg <= '0;
              is_read_reg <= shift_in[0];
              state_reg   <= (shift_in[7:0] == 8'h02 || shift_in[7:0] == 8'h03) ? ADDR : DRAIN;
            end
          end
        end
        ADDR: begin
          if (cs_s) begin
            state_reg <= IDLE;
          end else if (sclk_rise) begin
            shift_reg   <= shift_in;
            bit_cnt_reg <= bit_cnt_reg + 6'd1;
            if (bit_cnt_reg == 6'd31) begin
              bit_cnt_reg <= '0;
              adr_reg     <= shift_in;
              if (is_read_reg) begin
                state_reg    <= WB_RD;
                cyc_reg      <= 1'b1;
                stb_reg      <= 1'b1;
                we_reg       <= 1'b0;
                sel_reg      <= 4'hF;
                timer_reg    <= '0;
                turn_cnt_reg <= '0;
              end else begin
                state_reg <= WDATA;
              end
            end
          end
        end
        WDATA: begin
          if (cs_s) begin
            state_reg <= IDLE;
          end else if (sclk_rise) begin
            shift_reg   <= shift_in;
            bit_cnt_reg <= bit_cnt_reg + 6'd1;
            if (bit_cnt_reg == 6'd31) begin
              bit_cnt_reg <= '0;
              dat_reg     <= shift_in;
              state_reg   <= WB_WR;
              cyc_reg     <= 1'b1;
              stb_reg     <= 1'b1;
              we_reg      <= 1'b1;
              sel_reg     <= 4'hF;
              timer_reg   <= '0;
            end
          end
        end
        WB_WR: begin
          if (wbm.wbm_ack_i || timeout) begin
            cyc_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            err_reg   <= err_reg | ~wbm.wbm_ack_i;
            state_reg <= cs_s ? IDLE : DRAIN;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        WB_RD: begin
          // The host keeps clocking turnaround bits while the bus cycle is pending.
          if (sclk_rise && !turn_cnt_reg[3]) turn_cnt_reg <= turn_cnt_reg + 4'd1;
          if (wbm.wbm_ack_i || timeout) begin
            cyc_reg     <= 1'b0;
            stb_reg     <= 1'b0;
            sel_reg     <= '0;
            err_reg     <= err_reg | ~wbm.wbm_ack_i;
            rdata_reg   <= rd_value;
            bit_cnt_reg <= '0;
            if (cs_s) begin
              state_reg <= IDLE;
            end else if (turn_inc[3]) begin
              state_reg <= RDATA;
              miso_reg  <= rd_value[31];
            end else begin
              state_reg <= TURN;
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        TURN: begin
          if (cs_s) begin
            state_reg <= IDLE;
          end else if (sclk_rise) begin
            turn_cnt_reg <= turn_cnt_reg + 4'd1;
            if (turn_cnt_reg == 4'd7) begin
              state_reg <= RDATA;
              miso_reg  <= rdata_reg[31];
            end
          end
        end
        RDATA: begin
          if (cs_s) begin
            state_reg <= IDLE;
            miso_reg  <= 1'b0;
          end else begin
            // Bit 31 is already on the pin; only falls after a data rise advance.
            if (sclk_fall && bit_cnt_reg != 6'd0) begin
              rdata_reg <= {rdata_reg[30:0], 1'b0};
              miso_reg  <= rdata_reg[30];
            end
            if (sclk_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
              if (bit_cnt_reg == 6'd31) begin
                state_reg <= DRAIN;
                miso_reg  <= 1'b0;
              end
            end
          end
        end
        DRAIN: begin
          miso_reg <= 1'b0;
          if (cs_s) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_spi_wb_bridge.sv
// Directed bench: host SPI frames against a simple Wishbone slave model,
// checked with immediate assertions against hand-computed values.
module tb_gpio_spi_wb_bridge;

  localparam int TIMEOUT = 64;
  localparam int HALF    = 8;

  logic clk = 1'b0;
  logic rst;
  logic spi_sclk, spi_cs_n, spi_mosi;
  logic spi_miso, spi_miso_oeb, busy, err;

  gpio_spi_wb_bridge_if bus ();

  gpio_spi_wb_bridge #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oeb (spi_miso_oeb),
    .wbm          (bus.master),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave model: acks in the ack_delay-th stb cycle (0-based), -1 never acks.
  int          ack_delay = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          stb_k = 0, stb_total = 0, ack_total = 0, cyc_total = 0, late_total = 0;
  bit          acked_last = 1'b0;
  logic        cap_we;
  logic [3:0]  cap_sel;
  logic [31:0] cap_adr, cap_dat;

  always @(negedge clk) begin
    if (bus.wbm_cyc_o) cyc_total++;
    if (acked_last && bus.wbm_cyc_o) late_total++;
    acked_last    = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'hDEAD_BEEF;
    if (bus.wbm_stb_o) begin
      stb_total++;
      if (ack_delay >= 0 && stb_k == ack_delay) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = slave_rdata;
        ack_total++;
        acked_last = 1'b1;
        cap_we  = bus.wbm_we_o;
        cap_sel = bus.wbm_sel_o;
        cap_adr = bus.wbm_adr_o;
        cap_dat = bus.wbm_dat_o;
      end
      stb_k++;
    end else begin
      stb_k = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_xfer(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
    rx = 32'h0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      wait_clk(HALF);
      rx = {rx[30:0], spi_miso};
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    spi_sclk = 1'b0;
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, acc;
    int s_stb, s_ack, s_cyc, s_late, n;

    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    wait_clk(5);
    check("rst_cyc", bus.wbm_cyc_o, 0);
    check("rst_stb", bus.wbm_stb_o, 0);
    check("rst_sel", bus.wbm_sel_o, 0);
    check("rst_miso", spi_miso, 0);
    check("rst_oeb", spi_miso_oeb, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    wait_clk(4);

    // Write 02 / 3000_0004 / A5A5_1234, slave acks in the 4th stb cycle.
    ack_delay = 3;
    s_stb = stb_total; s_ack = ack_total; s_late = late_total;
    cs_low();
    check("wr_busy_start", busy, 1);
    spi_xfer(32'h02, 8, rx);
    spi_xfer(32'h3000_0004, 32, rx);
    spi_xfer(32'hA5A5_1234, 32, rx);
    wait_clk(30);
    check("wr_busy_drain", busy, 1);
    cs_high();
    check("wr_acks", ack_total - s_ack, 1);
    check("wr_stb_cycles", stb_total - s_stb, 4);
    check("wr_we", cap_we, 1);
    check("wr_sel", cap_sel, 4'hF);
    check("wr_adr", cap_adr, 32'h3000_0004);
    check("wr_dat", cap_dat, 32'hA5A5_1234);
    check("wr_cyc_drop", late_total - s_late, 0);
    check("wr_cyc_now", bus.wbm_cyc_o, 0);
    check("wr_err", err, 0);
    check("wr_busy_end", busy, 0);

    // Read 03 / 3000_0008, slave returns 0000_00C3 in the 3rd stb cycle.
    ack_delay = 2; slave_rdata = 32'h0000_00C3;
    s_ack = ack_total;
    cs_low();
    spi_xfer(32'h03, 8, rx);
    spi_xfer(32'h3000_0008, 32, rx);
    spi_xfer(32'h0, 8, rx);
    check("rd_oeb_low", spi_miso_oeb, 0);
    spi_xfer(32'h0, 32, rx);
    check("rd_data", rx, 32'h0000_00C3);
    check("rd_acks", ack_total - s_ack, 1);
    check("rd_we", cap_we, 0);
    check("rd_adr", cap_adr, 32'h3000_0008);
    check("rd_miso_drain", spi_miso, 0);
    cs_high();
    check("rd_oeb_high", spi_miso_oeb, 1);
    check("rd_err", err, 0);

    // Illegal command 7E then 64 clocks.
    s_cyc = cyc_total;
    cs_low();
    spi_xfer(32'h7E, 8, rx);
    spi_xfer(32'h0, 32, acc);
    spi_xfer(32'hFFFF_FFFF, 32, rx);
    acc = acc | rx;
    check("ill_miso", acc, 0);
    check("ill_busy", busy, 1);
    cs_high();
    check("ill_no_cyc", cyc_total - s_cyc, 0);
    check("ill_busy_end", busy, 0);

    // Abort after 20 bits of a write frame.
    s_cyc = cyc_total;
    cs_low();
    spi_xfer(32'h02, 8, rx);
    spi_xfer(32'h300, 12, rx);
    spi_cs_n = 1'b1;
    wait_clk(4);
    check("abort_idle", busy, 0);
    wait_clk(HALF);
    check("abort_no_cyc", cyc_total - s_cyc, 0);

    // Following write with an immediate ack.
    ack_delay = 0;
    s_ack = ack_total;
    cs_low();
    spi_xfer(32'h02, 8, rx);
    spi_xfer(32'h3000_0010, 32, rx);
    spi_xfer(32'h1234_5678, 32, rx);
    wait_clk(10);
    cs_high();
    check("wr2_acks", ack_total - s_ack, 1);
    check("wr2_adr", cap_adr, 32'h3000_0010);
    check("wr2_dat", cap_dat, 32'h1234_5678);

    // Read that never gets acked.
    ack_delay = -1;
    s_stb = stb_total; s_ack = ack_total;
    cs_low();
    spi_xfer(32'h03, 8, rx);
    spi_xfer(32'h3000_000C, 32, rx);
    spi_xfer(32'h0, 8, rx);
    spi_xfer(32'h0, 32, rx);
    cs_high();
    check("to_stb_cycles", stb_total - s_stb, TIMEOUT);
    check("to_no_ack", ack_total - s_ack, 0);
    check("to_data", rx, 32'hFFFF_FFFF);
    check("to_err", err, 1);

    // A good read afterwards: data correct, err still sticky.
    ack_delay = 1; slave_rdata = 32'h5A5A_0001;
    cs_low();
    spi_xfer(32'h03, 8, rx);
    spi_xfer(32'h3000_0000, 32, rx);
    spi_xfer(32'h0, 8, rx);
    spi_xfer(32'h0, 32, rx);
    cs_high();
    check("rd2_data", rx, 32'h5A5A_0001);
    check("err_sticky", err, 1);

    // Reset while a write cycle is stalled on the bus.
    ack_delay = -1;
    cs_low();
    spi_xfer(32'h02, 8, rx);
    spi_xfer(32'h3000_0014, 32, rx);
    spi_xfer(32'hCAFE_F00D, 32, rx);
    n = 0;
    while (!bus.wbm_stb_o && n < 200) begin
      wait_clk(1);
      n++;
    end
    check("rstmid_stb_seen", bus.wbm_stb_o, 1);
    rst = 1'b1;
    wait_clk(1);
    check("rstmid_cyc", bus.wbm_cyc_o, 0);
    check("rstmid_stb", bus.wbm_stb_o, 0);
    check("rstmid_we", bus.wbm_we_o, 0);
    check("rstmid_sel", bus.wbm_sel_o, 0);
    check("rstmid_adr", bus.wbm_adr_o, 0);
    check("rstmid_dat", bus.wbm_dat_o, 0);
    check("rstmid_oeb", spi_miso_oeb, 1);
    check("rstmid_idle", busy, 0);
    check("rstmid_err", err, 0);
    rst = 1'b0;
    cs_high();
    wait_clk(4);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
